// File: rtl/jtopl_eg_pkg.sv
// Shared types and constants for the final envelope attenuation pipe:
// KSL table, shift derivations from the attenuation width, slot index type.
package jtopl_eg_pkg;

  typedef logic [4:0] slot_t;

  // Headroom bits above the attenuation word; any set bit means saturate
  localparam int SAT_BITS = 2;

  localparam logic [7:0] KSL_LUT [16] = '{
    8'd0,  8'd32, 8'd40, 8'd45, 8'd48, 8'd51, 8'd53, 8'd55,
    8'd56, 8'd58, 8'd59, 8'd60, 8'd61, 8'd62, 8'd63, 8'd64
  };

  function automatic int tl_shift(input int egw);
    return egw - 7;
  endfunction

  function automatic int ksl_shift(input int egw);
    return egw - 9;
  endfunction

  // Key-scale attenuation; ksl selects the depth as a right shift of 4x base
  function automatic logic [8:0] ksl_db_calc(input logic [3:0] fnum,
                                             input logic [2:0] block,
                                             input logic [1:0] ksl);
    int base;
    base = int'(KSL_LUT[fnum]) - ((8 - int'(block)) << 3);
    if (base < 0 || ksl == 2'd0) return 9'd0;
    return 9'((base << 2) >> (~ksl));
  endfunction

endpackage

// File: rtl/jtopl_eg_tlramp.sv
// Per-slot effective TL memory: snaps on first visit or tl_snap, then
// slews one step per visit toward the programmed TL.
module jtopl_eg_tlramp
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  slot_t      slot,
  input  logic [5:0] tl,
  input  logic       tl_snap,
  output logic [5:0] tl_eff
);

  logic [5:0]       tl_mem [SLOTS];
  logic [SLOTS-1:0] init;
  logic [5:0]       cur;

  assign cur = tl_mem[slot];

  always_comb begin
    tl_eff = cur;
    if (!init[slot] || tl_snap) tl_eff = tl;
    else if (cur < tl)          tl_eff = cur + 6'd1;
    else if (cur > tl)          tl_eff = cur - 6'd1;
  end

  // Memory contents are meaningless until the matching init bit is set
  always_ff @(posedge clk) begin
    if (cen) tl_mem[slot] <= tl_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      init       <= '0;
    else if (cen) init[slot] <= 1'b1;
  end

endmodule

// File: rtl/jtopl_eg_final_pipe.sv
// Three-stage slot-multiplexed final EG attenuation: TL + KSL + AM + EG, saturated.
// Optional TL ramping per slot is enabled by defining JTOPL_TL_RAMP_EN.
module jtopl_eg_final_pipe
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = 18,
  parameter int EGW   = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           zero,
  input  logic [3:0]     lfo_mod,
  input  logic [3:0]     fnum,
  input  logic [2:0]     block,
  input  logic           amsen,
  input  logic           ams,
  input  logic [5:0]     tl,
  input  logic [1:0]     ksl,
  input  logic           tl_snap,
  input  logic [EGW-1:0] eg_pure_in,
  output logic [EGW-1:0] eg_limited,
  output logic [4:0]     slot_out,
  output logic           zero_out,
  output logic           valid_out
);

  localparam int TL_SHIFT  = tl_shift(EGW);
  localparam int KSL_SHIFT = ksl_shift(EGW);
  localparam int SW        = EGW + SAT_BITS;

  // Handshake: every cen strobe accepts one input sample (no backpressure);
  // valid_out rises with the first sample leaving S3 and stays high until rst.

  slot_t slot_cnt, slot_cur;
  assign slot_cur = zero ? '0 : slot_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      slot_cnt <= '0;
    else if (cen) slot_cnt <= (slot_cur == slot_t'(SLOTS - 1)) ? '0 : slot_cur + 5'd1;
  end

  logic [5:0] tl_eff;
`ifdef JTOPL_TL_RAMP_EN
  jtopl_eg_tlramp #(.SLOTS(SLOTS)) u_tlramp (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .slot    (slot_cur),
    .tl      (tl),
    .tl_snap (tl_snap),
    .tl_eff  (tl_eff)
  );
`else
  logic unused_tl_snap;
  assign unused_tl_snap = tl_snap;
  assign tl_eff         = tl;
`endif

  logic [5:0] am_d;
  always_comb begin
    am_d = 6'd0;
    if (amsen) am_d = ams ? {lfo_mod, 2'b00} : {2'b00, lfo_mod};
  end

  // S1: operand resolution
  logic           s1_valid;
  slot_t          s1_slot;
  logic [8:0]     s1_ksl;
  logic [5:0]     s1_am;
  logic [5:0]     s1_tl;
  logic [EGW-1:0] s1_eg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_slot  <= '0;
      s1_ksl   <= '0;
      s1_am    <= '0;
      s1_tl    <= '0;
      s1_eg    <= '0;
    end else if (cen) begin
      s1_valid <= 1'b1;
      s1_slot  <= slot_cur;
      s1_ksl   <= ksl_db_calc(fnum, block, ksl);
      s1_am    <= am_d;
      s1_tl    <= tl_eff;
      s1_eg    <= eg_pure_in;
    end
  end

  // S2: widened sum, cannot overflow SW bits at the operand maxima
  logic          s2_valid;
  slot_t         s2_slot;
  logic [SW-1:0] s2_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_slot  <= '0;
      s2_sum   <= '0;
    end else if (cen) begin
      s2_valid <= s1_valid;
      s2_slot  <= s1_slot;
      s2_sum   <= (SW'(s1_tl) << TL_SHIFT) + (SW'(s1_ksl) << KSL_SHIFT)
                + SW'(s1_eg) + SW'(s1_am);
    end
  end

  // S3: saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eg_limited <= '1;
      slot_out   <= '0;
      zero_out   <= 1'b0;
      valid_out  <= 1'b0;
    end else if (cen && s2_valid) begin
      eg_limited <= (|s2_sum[SW-1:EGW]) ? '1 : s2_sum[EGW-1:0];
      slot_out   <= s2_slot;
      zero_out   <= (s2_slot == '0);
      valid_out  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtopl_eg_final_pipe.sv
// Scoreboard bench for jtopl_eg_final_pipe: driver pushes expected {slot, eg},
// monitor pops and compares on every cen strobe once the pipe is full.
module tb_jtopl_eg_final_pipe;
  localparam int SLOTS = 18;
  localparam int EGW   = 10;

`ifdef JTOPL_TL_RAMP_EN
  localparam int RAMP_A = 88;
  localparam int RAMP_B = 96;
`else
  localparam int RAMP_A = 104;
  localparam int RAMP_B = 104;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cen = 1'b0;
  logic           zero = 1'b0;
  logic [3:0]     lfo_mod = '0;
  logic [3:0]     fnum = '0;
  logic [2:0]     block = '0;
  logic           amsen = 1'b0;
  logic           ams = 1'b0;
  logic [5:0]     tl = '0;
  logic [1:0]     ksl = '0;
  logic           tl_snap = 1'b0;
  logic [EGW-1:0] eg_pure_in = '0;
  logic [EGW-1:0] eg_limited;
  logic [4:0]     slot_out;
  logic           zero_out;
  logic           valid_out;

  jtopl_eg_final_pipe #(.SLOTS(SLOTS), .EGW(EGW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .zero       (zero),
    .lfo_mod    (lfo_mod),
    .fnum       (fnum),
    .block      (block),
    .amsen      (amsen),
    .ams        (ams),
    .tl         (tl),
    .ksl        (ksl),
    .tl_snap    (tl_snap),
    .eg_pure_in (eg_pure_in),
    .eg_limited (eg_limited),
    .slot_out   (slot_out),
    .zero_out   (zero_out),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tb_cnt = 0;
  int strobe_cnt = 0;
  logic [EGW+4:0] exp_q[$];
  logic [EGW-1:0] last_exp = '1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic strobe(input logic z, input logic [3:0] f, input logic [2:0] b,
                        input logic [1:0] k, input logic [5:0] t, input logic snap,
                        input logic [3:0] lfo, input logic ae, input logic as,
                        input logic [EGW-1:0] eg, input logic [EGW-1:0] exp_eg);
    int s;
    s = z ? 0 : tb_cnt;
    tb_cnt = (s == SLOTS - 1) ? 0 : s + 1;
    zero = z; fnum = f; block = b; ksl = k; tl = t; tl_snap = snap;
    lfo_mod = lfo; amsen = ae; ams = as; eg_pure_in = eg;
    cen = 1'b1;
    exp_q.push_back({5'(s), exp_eg});
    @(negedge clk);
    cen = 1'b0;
  endtask

  task automatic plain(input logic z, input logic [EGW-1:0] eg);
    strobe(z, 4'd0, 3'd0, 2'd0, 6'd0, 1'b1, 4'd0, 1'b0, 1'b0, eg, eg);
  endtask

  task automatic tlvisit(input logic z, input logic [5:0] t, input logic snap,
                         input logic [EGW-1:0] exp_eg);
    strobe(z, 4'd0, 3'd0, 2'd0, t, snap, 4'd0, 1'b0, 1'b0, '0, exp_eg);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  initial begin : monitor
    logic c, r;
    logic [EGW+4:0] e;
    forever begin
      @(posedge clk);
      c = cen;
      r = rst;
      #1;
      if (r || rst) begin
        strobe_cnt = 0;
        last_exp = '1;
      end else if (c) begin
        strobe_cnt++;
        if (strobe_cnt >= 3) begin
          if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            last_exp = e[EGW-1:0];
            check("eg_limited", eg_limited, e[EGW-1:0]);
            check("slot_out", slot_out, e[EGW+4:EGW]);
            check("zero_out", zero_out, (e[EGW+4:EGW] == 5'd0) ? 1 : 0);
            check("valid_out", valid_out, 1);
          end
        end else begin
          check("valid_pre", valid_out, 0);
          check("eg_pre", eg_limited, (1 << EGW) - 1);
        end
      end else if (strobe_cnt >= 3) begin
        check("hold_gap", eg_limited, last_exp);
      end
    end
  end

  initial begin
    gap(3);
    check("rst_eg", eg_limited, 10'h3FF);
    check("rst_slot", slot_out, 0);
    check("rst_zero", zero_out, 0);
    check("rst_valid", valid_out, 0);
    rst = 1'b0;
    gap(1);

    // Clean path and latency with cen gaps
    plain(1'b1, 10'h123);
    gap(2);
    plain(1'b0, 10'h0AA);
    gap(3);
    // KSL + TL
    strobe(1'b0, 4'd15, 3'd7, 2'd3, 6'd4, 1'b1, 4'd0, 1'b0, 1'b0, 10'h000, 10'd480);
    strobe(1'b0, 4'd15, 3'd7, 2'd1, 6'd4, 1'b1, 4'd0, 1'b0, 1'b0, 10'h000, 10'd144);
    strobe(1'b0, 4'd15, 3'd0, 2'd3, 6'd4, 1'b1, 4'd0, 1'b0, 1'b0, 10'h000, 10'd32);
    strobe(1'b0, 4'd15, 3'd7, 2'd2, 6'd0, 1'b1, 4'd0, 1'b0, 1'b0, 10'h000, 10'd224);
    strobe(1'b0, 4'd8,  3'd5, 2'd3, 6'd0, 1'b1, 4'd0, 1'b0, 1'b0, 10'h000, 10'd256);
    strobe(1'b0, 4'd1,  3'd4, 2'd3, 6'd0, 1'b1, 4'd0, 1'b0, 1'b0, 10'h010, 10'h010);
    // AM depth
    strobe(1'b0, 4'd0, 3'd0, 2'd0, 6'd0, 1'b1, 4'd5, 1'b1, 1'b0, 10'h100, 10'h105);
    strobe(1'b0, 4'd0, 3'd0, 2'd0, 6'd0, 1'b1, 4'd5, 1'b1, 1'b1, 10'h100, 10'h114);
    strobe(1'b0, 4'd0, 3'd0, 2'd0, 6'd0, 1'b1, 4'd5, 1'b0, 1'b1, 10'h100, 10'h100);
    // Saturation boundary
    strobe(1'b0, 4'd0, 3'd0, 2'd0, 6'd63, 1'b1, 4'd15, 1'b1, 1'b1, 10'h3FF, 10'h3FF);
    strobe(1'b0, 4'd0, 3'd0, 2'd0, 6'd0, 1'b1, 4'd1, 1'b1, 1'b0, 10'h3FE, 10'h3FF);
    strobe(1'b0, 4'd0, 3'd0, 2'd0, 6'd1, 1'b1, 4'd0, 1'b0, 1'b0, 10'h3F7, 10'h3FF);
    strobe(1'b0, 4'd0, 3'd0, 2'd0, 6'd1, 1'b1, 4'd0, 1'b0, 1'b0, 10'h3F8, 10'h3FF);
    strobe(1'b0, 4'd0, 3'd0, 2'd0, 6'd1, 1'b1, 4'd0, 1'b0, 1'b0, 10'h3F6, 10'h3FE);

    // Free run: zero only at the start, tags 0..17, 0..17, 0..3
    for (int i = 0; i < 40; i++) begin
      plain(i == 0, 10'($urandom_range(0, 1023)));
      if ($urandom_range(0, 3) == 0) gap(1);
    end
    // Early zero after slot 9
    plain(1'b1, 10'h001);
    for (int i = 0; i < 9; i++) plain(1'b0, 10'(i + 2));
    plain(1'b1, 10'h055);
    plain(1'b0, 10'h056);
    gap(2);

    // Async reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_eg", eg_limited, 10'h3FF);
    check("mid_rst_slot", slot_out, 0);
    check("mid_rst_zero", zero_out, 0);
    check("mid_rst_valid", valid_out, 0);
    exp_q.delete();
    tb_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    gap(1);

    // TL visits after release: slot 0 re-snaps, slot 1 first visit, then ramp
    tlvisit(1'b0, 6'd20, 1'b0, 10'd160);
    tlvisit(1'b0, 6'd10, 1'b0, 10'd80);
    tlvisit(1'b1, 6'd20, 1'b0, 10'd160);
    tlvisit(1'b0, 6'd13, 1'b0, 10'(RAMP_A));
    tlvisit(1'b1, 6'd20, 1'b0, 10'd160);
    tlvisit(1'b0, 6'd13, 1'b0, 10'(RAMP_B));
    tlvisit(1'b1, 6'd20, 1'b0, 10'd160);
    tlvisit(1'b0, 6'd13, 1'b0, 10'd104);
    tlvisit(1'b1, 6'd20, 1'b0, 10'd160);
    tlvisit(1'b0, 6'd40, 1'b1, 10'd320);
    tlvisit(1'b1, 6'd20, 1'b0, 10'd160);

    // Flush the last checked samples through the pipe
    repeat (3) plain(1'b0, 10'h000);
    gap(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
